// File: rtl/uart_pkg.sv
// Shared UART types and helpers: FSM state encoding, tick divider, frame width.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO: head is always on data_o; push and pop may coincide.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] data_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 oversampling UART receiver with byte FIFO and error pulses.
// UART_RX_MAJORITY_EN: 2-of-3 vote over ticks MID-2..MID instead of one sample at MID-1.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 125_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  input  logic                      rd_en_i,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      fifo_empty_o,
  output logic                      fifo_full_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int DIV_W    = $clog2(TICK_DIV + 1);
  localparam int TCK_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(UART_DATA_BITS);
  localparam int MID      = OVERSAMPLE / 2;

  uart_state_e               state_q, state_d;
  logic                      rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [DIV_W-1:0]          div_cnt_q, div_cnt_d;
  logic [TCK_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      samp_mid_q, samp_mid_d;
  logic                      frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic                      tick, decide, bit_val, push;
`ifdef UART_RX_MAJORITY_EN
  logic                      samp_lo_q, samp_lo_d;
`endif

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

  assign tick   = (state_q != IDLE) && (div_cnt_q == DIV_W'(TICK_DIV - 1));
  assign decide = tick && (tick_cnt_q == TCK_W'(MID));

`ifdef UART_RX_MAJORITY_EN
  assign bit_val = (samp_lo_q & samp_mid_q) | (samp_lo_q & rx_sync_q) | (samp_mid_q & rx_sync_q);
`else
  assign bit_val = samp_mid_q;
`endif

  always_comb begin
    rx_meta_d   = rx_i;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    samp_mid_d  = samp_mid_q;
`ifdef UART_RX_MAJORITY_EN
    samp_lo_d   = samp_lo_q;
`endif
    frame_err_d = 1'b0;
    push        = 1'b0;

    // Tick and bit-phase counters run only inside a frame and restart from zero on each start edge.
    if (state_q == IDLE) begin
      div_cnt_d  = '0;
      tick_cnt_d = '0;
    end else begin
      div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    end

    if (tick) begin
      tick_cnt_d = (tick_cnt_q == TCK_W'(OVERSAMPLE - 1)) ? '0 : tick_cnt_q + TCK_W'(1);
      if (tick_cnt_q == TCK_W'(MID - 1)) samp_mid_d = rx_sync_q;
`ifdef UART_RX_MAJORITY_EN
      if (tick_cnt_q == TCK_W'(MID - 2)) samp_lo_d = rx_sync_q;
`endif
    end

    // Each decision lands one bit after the previous one, so states advance at decision ticks.
    unique case (state_q)
      IDLE: if (rx_prev_q && !rx_sync_q) state_d = START;
      START: begin
        if (decide) begin
          state_d   = bit_val ? IDLE : DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (decide) begin
          shift_d   = {bit_val, shift_q[UART_DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BIT_W'(1);
          if (bit_idx_q == BIT_W'(UART_DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (decide) begin
          push        = bit_val;
          frame_err_d = ~bit_val;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    overrun_d = push & fifo_full_o & ~rd_en_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      samp_mid_q  <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
      samp_lo_q   <= 1'b1;
`endif
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      samp_mid_q  <= samp_mid_d;
`ifdef UART_RX_MAJORITY_EN
      samp_lo_q   <= samp_lo_d;
`endif
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  sync_fifo #(
    .DW   (UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(shift_q),
    .pop_i      (rd_en_i),
    .data_o     (data_o),
    .empty_o    (fifo_empty_o),
    .full_o     (fifo_full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, glitches, errors, overrun, mid-frame reset.
module tb_uart_rx;

  localparam int D        = 6;               // clocks per tick
  localparam int OS       = 16;
  localparam int BAUD     = 115_200;
  localparam int CLK_FREQ = BAUD * OS * D;
  localparam int BIT      = OS * D;          // 96 clocks per bit

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rd_en_i = 1'b0;
  logic [7:0] data_o;
  logic       fifo_empty_o, fifo_full_o, frame_err_o, overrun_o;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q [$];

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rd_en_i     (rd_en_i),
    .data_o      (data_o),
    .fifo_empty_o(fifo_empty_o),
    .fifo_full_o (fifo_full_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #4 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts pulse cycles and checks every popped head against the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_err_o) ferr_cnt++;
        if (overrun_o)   ovr_cnt++;
        if (rd_en_i && !fifo_empty_o) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pop_unexpected: got 0x%0h expected no byte", data_o);
          end else begin
            e = exp_q.pop_front();
            if (data_o !== e) begin
              bad++;
              $display("FAIL pop_data: got 0x%0h expected 0x%0h", data_o, e);
            end
          end
        end
      end
    end
  end

  task automatic hold(input logic v, input int n);
    rx_i = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // glitch_bit >= 0 places a one-tick high pulse over the MID-1 sample of that data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_v, input bit exp_en, input int glitch_bit);
    if (exp_en) exp_q.push_back(b);
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        hold(b[i], 8 * D - 2);
        hold(1'b1, D);
        hold(b[i], BIT - 9 * D + 2);
      end else begin
        hold(b[i], BIT);
      end
    end
    hold(stop_v, BIT);
    rx_i = 1'b1;
  endtask

  task automatic read_byte();
    int n = 0;
    while (fifo_empty_o && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (fifo_empty_o) begin
      total++; bad++;
      $display("FAIL read_timeout: got empty=1 expected a byte within 3000 clk");
    end else begin
      @(posedge clk); #1 rd_en_i = 1'b1;
      @(posedge clk); #1 rd_en_i = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int ferr0, ovr0;
    repeat (3) @(negedge clk);
    check("rst_data", data_o, 8'h00);
    check("rst_empty", fifo_empty_o, 1);
    check("rst_full", fifo_full_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    hold(1'b1, 20);

    // Two back-to-back frames, first-byte latency about 9.5 bit times.
    cyc = 0;
    fork
      begin send_byte(8'hA5, 1'b1, 1, -1); send_byte(8'h3C, 1'b1, 1, -1); end
      begin
        while (fifo_empty_o && cyc < 3000) begin @(posedge clk); #1; cyc++; end
      end
    join
    check("first_visible", (cyc >= 912 && cyc <= 930), 1);
    check("first_head", data_o, 8'hA5);
    read_byte();
    read_byte();
    @(negedge clk);
    check("empty_after_two_pops", fifo_empty_o, 1);

    // Short low pulse: start rejected, nothing else happens.
    ferr0 = ferr_cnt; ovr0 = ovr_cnt;
    hold(1'b0, 3 * D);
    hold(1'b1, 3 * BIT);
    check("glitch_empty", fifo_empty_o, 1);
    check("glitch_ferr", ferr_cnt - ferr0, 0);
    check("glitch_ovr", ovr_cnt - ovr0, 0);

    // Framing error then a valid frame.
    ferr0 = ferr_cnt;
    send_byte(8'h3C, 1'b0, 0, -1);
    hold(1'b1, 20);
    check("ferr_pulses", ferr_cnt - ferr0, 1);
    check("ferr_empty", fifo_empty_o, 1);
    send_byte(8'h11, 1'b1, 1, -1);
    read_byte();

    // Fill the FIFO, then overrun.
    ovr0 = ovr_cnt;
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1, 1, -1);
    @(negedge clk);
    check("full_after_16", fifo_full_o, 1);
    check("no_ovr_at_16", ovr_cnt - ovr0, 0);
    send_byte(8'h10, 1'b1, 0, -1);
    @(negedge clk);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("still_full", fifo_full_o, 1);
    for (int i = 0; i < 16; i++) read_byte();
    @(negedge clk);
    check("empty_after_drain", fifo_empty_o, 1);

    // Glitch inside bit 3 of a 0x00 frame.
`ifdef UART_RX_MAJORITY_EN
    send_byte(8'h00, 1'b1, 0, 3); exp_q.push_back(8'h00);
`else
    send_byte(8'h00, 1'b1, 0, 3); exp_q.push_back(8'h08);
`endif
    read_byte();

    // Reset mid-frame with a stale byte in the FIFO.
    send_byte(8'h77, 1'b1, 0, -1);
    hold(1'b1, 10);
    check("stale_present", fifo_empty_o, 0);
    ferr0 = ferr_cnt; ovr0 = ovr_cnt;
    fork
      send_byte(8'hF0, 1'b1, 0, -1);
      begin
        repeat (5 * BIT + 40) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_empty", fifo_empty_o, 1);
        check("midrst_data", data_o, 8'h00);
        check("midrst_full", fifo_full_o, 0);
        @(posedge clk); #1 rst = 1'b0;
      end
    join
    hold(1'b1, 2 * BIT);
    check("postrst_empty", fifo_empty_o, 1);
    check("postrst_ferr", ferr_cnt - ferr0, 0);
    check("postrst_ovr", ovr_cnt - ovr0, 0);
    send_byte(8'h5A, 1'b1, 1, -1);
    read_byte();
    @(negedge clk);
    check("final_empty", fifo_empty_o, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
